// File: rtl/dm_access_pkg.sv
// Shared types and constants for the data-memory load/store sequencer.
package dm_access_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Size code 11 is handled as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    if (size == SIZE_H) return lo[0];
    if (is_word(size))  return lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Core-side request/response bundle of dm_access_unit.
// addr_err exists only when DM_ALIGN_CHECK_EN is defined.
interface dm_access_unit_if;
  logic        req;
  logic        st;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
`ifdef DM_ALIGN_CHECK_EN
  logic        addr_err;

  modport master (output req, st, size, sext, addr, wdata,
                  input  busy, done, rdata, addr_err);
  modport slave  (input  req, st, size, sext, addr, wdata,
                  output busy, done, rdata, addr_err);
`else
  modport master (output req, st, size, sext, addr, wdata,
                  input  busy, done, rdata);
  modport slave  (input  req, st, size, sext, addr, wdata,
                  output busy, done, rdata);
`endif
endinterface

// File: rtl/dm_1k.sv
// 1 KB word-organised data memory: synchronous write, combinational read.
module dm_1k (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/dm_lane_mux.sv
// Little-endian byte-lane steering: load extract/extend and store merge.
module dm_lane_mux
  import dm_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sext,
  input  logic [31:0] ld_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = ld_word[{lo, 3'b000} +: 8];
    half_v  = ld_word[{lo[1], 4'b0000} +: 16];
    ld_data = ld_word;
    st_word = wdata;
    case (size)
      SIZE_B: begin
        ld_data = {{24{sext & byte_v[7]}}, byte_v};
        st_word = old_word;
        st_word[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        // addr[0] is ignored: the half lane is chosen by addr[1] alone
        ld_data = {{16{sext & half_v[15]}}, half_v};
        st_word = old_word;
        st_word[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = ld_word;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store sequencer between datapath and dm_1k (read-modify-write for sub-word stores).
// Optional DM_ALIGN_CHECK_EN: misaligned accesses complete at once with addr_err.
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  dm_access_unit_if.slave    core,
  output logic [ADDR_W-1:0]  dm_addr,
  output logic [31:0]        dm_din,
  output logic               dm_we,
  input  logic [31:0]        dm_dout
);

  state_e              state_q, state_d;
  logic                st_q, st_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         ld_data;
  logic [31:0]         st_word;
`ifdef DM_ALIGN_CHECK_EN
  logic                err_q, err_d;
`endif

  dm_lane_mux u_lane_mux (
    .size     (size_q),
    .lo       (addr_q[1:0]),
    .sext     (sext_q),
    .ld_word  (dm_dout),
    .old_word (merge_q),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
`ifdef DM_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (core.req) begin
          st_d    = core.st;
          size_d  = core.size;
          sext_d  = core.sext;
          addr_d  = core.addr[ADDR_W-1:0];
          wdata_d = core.wdata;
`ifdef DM_ALIGN_CHECK_EN
          err_d   = misaligned(core.size, core.addr[1:0]);
          if (err_d) state_d = ST_DONE;
          else state_d = (core.st && is_word(core.size)) ? ST_WRITE : ST_READ;
`else
          state_d = (core.st && is_word(core.size)) ? ST_WRITE : ST_READ;
`endif
        end
      end
      ST_READ: begin
        merge_d = dm_dout;
        if (st_q) begin
          state_d = ST_WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = ST_DONE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      st_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
`ifdef DM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
`ifdef DM_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign dm_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_we      = (state_q == ST_WRITE);
  assign dm_din     = (state_q == ST_WRITE) ? st_word : '0;
  assign core.busy  = (state_q != ST_IDLE);
  assign core.done  = (state_q == ST_DONE);
  assign core.rdata = rdata_q;
`ifdef DM_ALIGN_CHECK_EN
  assign core.addr_err = (state_q == ST_DONE) && err_q;
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed, table-driven bench for dm_access_unit with a dm_1k behind it.
module tb_dm_access_unit;
  import dm_access_pkg::*;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_word;   // dm_din for stores, rdata for loads
    logic [9:0]  exp_daddr;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_we;

  int n_pass  = 0;
  int n_total = 0;

  dm_access_unit_if bus ();

  dm_access_unit #(.ADDR_W(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .core    (bus),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_we   (dm_we),
    .dm_dout (dm_dout)
  );

  dm_1k u_mem (
    .clk  (clk),
    .we   (dm_we),
    .addr (dm_addr[9:2]),
    .din  (dm_din),
    .dout (dm_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_word, input logic [9:0] exp_daddr,
                              input int exp_lat);
    vec_t v;
    v.st = st; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.exp_word = exp_word; v.exp_daddr = exp_daddr; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic do_op(input logic st, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int we_cnt, output logic [31:0] din_seen,
                       output logic [9:0] daddr_seen, output logic err_seen);
    @(negedge clk);
    bus.req = 1'b1; bus.st = st; bus.size = size; bus.sext = sext;
    bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    lat = 0; we_cnt = 0; din_seen = '0; daddr_seen = '0; err_seen = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) daddr_seen = dm_addr;
      if (dm_we) begin
        we_cnt++;
        din_seen = dm_din;
      end
      if (bus.done) begin
        lat = c;
`ifdef DM_ALIGN_CHECK_EN
        err_seen = bus.addr_err;
`endif
        bus.req = 1'b0;
        break;
      end
    end
    if (lat == 0) begin
      bus.req = 1'b0;
      n_total++;
      $display("FAIL done_timeout: no done within 16 cycles for addr 0x%08h", addr);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    int          lat, we_cnt, done_cnt, done_at;
    logic [31:0] din_seen, last_rd;
    logic [9:0]  daddr_seen;
    logic        err_seen;

    vecs.push_back(mk(1, SIZE_W, 0, 32'h4,        32'h00000100, 32'h00000100, 10'h004, 2));
    vecs.push_back(mk(0, SIZE_W, 0, 32'h4,        32'h0,        32'h00000100, 10'h004, 2));
    vecs.push_back(mk(1, SIZE_W, 0, 32'h8,        32'h11223344, 32'h11223344, 10'h008, 2));
    vecs.push_back(mk(1, SIZE_B, 0, 32'h9,        32'hFFFFFFAB, 32'h1122AB44, 10'h008, 3));
    vecs.push_back(mk(0, SIZE_W, 0, 32'h8,        32'h0,        32'h1122AB44, 10'h008, 2));
    vecs.push_back(mk(1, SIZE_W, 0, 32'h0,        32'h8000FF80, 32'h8000FF80, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_B, 1, 32'h0,        32'h0,        32'hFFFFFF80, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_B, 0, 32'h0,        32'h0,        32'h00000080, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_H, 1, 32'h2,        32'h0,        32'hFFFF8000, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_H, 0, 32'h2,        32'h0,        32'h00008000, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_B, 1, 32'h1,        32'h0,        32'hFFFFFFFF, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_H, 0, 32'h0,        32'h0,        32'h0000FF80, 10'h000, 2));
    vecs.push_back(mk(0, SIZE_B, 1, 32'h3,        32'h0,        32'hFFFFFF80, 10'h000, 2));
    vecs.push_back(mk(1, SIZE_H, 0, 32'hA,        32'h1234BEEF, 32'hBEEFAB44, 10'h008, 3));
    vecs.push_back(mk(1, SIZE_B, 0, 32'hB,        32'h0000005A, 32'h5AEFAB44, 10'h008, 3));
    vecs.push_back(mk(0, SIZE_W, 0, 32'hFFFFFC08, 32'h0,        32'h5AEFAB44, 10'h008, 2));
    vecs.push_back(mk(1, 2'b11,  0, 32'h40C,      32'hCAFEF00D, 32'hCAFEF00D, 10'h00C, 2));
    vecs.push_back(mk(0, 2'b11,  0, 32'hC,        32'h0,        32'hCAFEF00D, 10'h00C, 2));
    vecs.push_back(mk(0, SIZE_B, 0, 32'hB,        32'h0,        32'h0000005A, 10'h008, 2));
    vecs.push_back(mk(0, SIZE_B, 1, 32'hA,        32'h0,        32'hFFFFFFEF, 10'h008, 2));
    vecs.push_back(mk(1, SIZE_W, 0, 32'h10,       32'hA0A0A0A0, 32'hA0A0A0A0, 10'h010, 2));
    vecs.push_back(mk(1, SIZE_W, 0, 32'h14,       32'h55555555, 32'h55555555, 10'h014, 2));
`ifndef DM_ALIGN_CHECK_EN
    vecs.push_back(mk(0, SIZE_W, 0, 32'h6,        32'h0,        32'h00000100, 10'h004, 2));
    vecs.push_back(mk(0, SIZE_H, 1, 32'h3,        32'h0,        32'hFFFF8000, 10'h000, 2));
`endif

    reset = 1'b1;
    bus.req = 1'b0; bus.st = 1'b0; bus.size = '0; bus.sext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy",  {31'b0, bus.busy}, 32'h0);
    chk("reset_done",  {31'b0, bus.done}, 32'h0);
    chk("reset_we",    {31'b0, dm_we},    32'h0);
    chk("reset_rdata", bus.rdata,         32'h0);
    chk("reset_daddr", {22'b0, dm_addr},  32'h0);
    chk("reset_din",   dm_din,            32'h0);
    reset = 1'b0;

    last_rd = '0;
    foreach (vecs[i]) begin
      do_op(vecs[i].st, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
            lat, we_cnt, din_seen, daddr_seen, err_seen);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_we_count", i), we_cnt, vecs[i].st ? 1 : 0);
      chk($sformatf("v%0d_dm_addr", i), {22'b0, daddr_seen}, {22'b0, vecs[i].exp_daddr});
      if (vecs[i].st) begin
        chk($sformatf("v%0d_dm_din", i), din_seen, vecs[i].exp_word);
      end else begin
        last_rd = vecs[i].exp_word;
      end
      chk($sformatf("v%0d_rdata", i), bus.rdata, last_rd);
`ifdef DM_ALIGN_CHECK_EN
      chk($sformatf("v%0d_addr_err", i), {31'b0, err_seen}, 32'h0);
`endif
    end

`ifdef DM_ALIGN_CHECK_EN
    do_op(1'b0, SIZE_W, 1'b0, 32'h6, 32'h0, lat, we_cnt, din_seen, daddr_seen, err_seen);
    chk("misalign_latency",  lat, 1);
    chk("misalign_addr_err", {31'b0, err_seen}, 32'h1);
    chk("misalign_we_count", we_cnt, 0);
    chk("misalign_rdata",    bus.rdata, last_rd);
    do_op(1'b1, SIZE_H, 1'b0, 32'h9, 32'hFFFF, lat, we_cnt, din_seen, daddr_seen, err_seen);
    chk("misalign_sh_err",   {31'b0, err_seen}, 32'h1);
    chk("misalign_sh_we",    we_cnt, 0);
    do_op(1'b0, SIZE_W, 1'b0, 32'h8, 32'h0, lat, we_cnt, din_seen, daddr_seen, err_seen);
    chk("misalign_sh_nowrite", bus.rdata, 32'h5AEFAB44);
`endif

    // Reset asserted while a halfword store sits in READ.
    @(negedge clk);
    bus.req = 1'b1; bus.st = 1'b1; bus.size = SIZE_H; bus.sext = 1'b0;
    bus.addr = 32'hC; bus.wdata = 32'h00007777;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", {31'b0, bus.busy}, 32'h1);
    reset = 1'b1;
    bus.req = 1'b0;
    #1;
    chk("rst_mid_busy",  {31'b0, bus.busy}, 32'h0);
    chk("rst_mid_we",    {31'b0, dm_we},    32'h0);
    chk("rst_mid_rdata", bus.rdata,         32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b0, SIZE_W, 1'b0, 32'hC, 32'h0, lat, we_cnt, din_seen, daddr_seen, err_seen);
    chk("rst_mid_word_kept", bus.rdata, 32'hCAFEF00D);

    // req dropped and re-raised while busy, and held through DONE.
    @(negedge clk);
    bus.req = 1'b1; bus.st = 1'b1; bus.size = SIZE_B; bus.sext = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'h00000011;
    @(posedge clk);
    we_cnt = 0; done_cnt = 0; done_at = 0; din_seen = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_we) begin
        we_cnt++;
        din_seen = dm_din;
      end
      if (bus.done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 1) bus.req = 1'b0;
      if (c == 2) begin
        bus.req = 1'b1; bus.size = SIZE_W; bus.addr = 32'h14; bus.wdata = 32'hDEADBEEF;
      end
      if (done_at != 0 && c == done_at + 1) bus.req = 1'b0;
    end
    chk("toggle_done_count", done_cnt, 1);
    chk("toggle_done_cycle", done_at, 3);
    chk("toggle_we_count",   we_cnt, 1);
    chk("toggle_dm_din",     din_seen, 32'hA0A0A011);
    chk("toggle_idle_after", {31'b0, bus.busy}, 32'h0);
    do_op(1'b0, SIZE_W, 1'b0, 32'h14, 32'h0, lat, we_cnt, din_seen, daddr_seen, err_seen);
    chk("toggle_no_extra_store", bus.rdata, 32'h55555555);
    do_op(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, lat, we_cnt, din_seen, daddr_seen, err_seen);
    chk("toggle_stored_word", bus.rdata, 32'hA0A0A011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
